// File: rtl/mult_pkg.sv
// Shared types and helpers for the tile-based sequential multiplier.
// Defaults describe the 16x16 build with 8x8 tiles.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int TILE_DEF  = 8;
    localparam int K         = WIDTH_DEF / TILE_DEF;
    localparam int CNT_W     = $clog2(K * K);
    localparam int ACC_W     = 2 * WIDTH_DEF;

    // Bit offset of partial product (i,j) inside the full product.
    function automatic int tile_shift(input int i, input int j, input int tile);
        return tile * (i + j);
    endfunction

endpackage

// File: rtl/tile_mul_wallace.sv
// Combinational TILE x TILE unsigned multiplier.
// The partial-product matrix is reduced column by column with FA/HA cells, then two rows are added.
module tile_mul_wallace #(
    parameter int TILE = 8
) (
    input  logic [TILE-1:0]   a,
    input  logic [TILE-1:0]   b,
    output logic [2*TILE-1:0] p
);

    localparam int COLS = 2 * TILE;

    // Returns {carry, sum}.
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic            cur [COLS][TILE];
    logic            nxt [COLS][TILE];
    int              hgt [COLS];
    int              nh  [COLS];
    int              maxh;
    logic [1:0]      cs;
    logic [COLS-1:0] row0;
    logic [COLS-1:0] row1;

    // Each stage groups a column's bits in threes; it stops once no column is taller than two.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            hgt[c] = 0;
            nh[c]  = 0;
            for (int r = 0; r < TILE; r++) begin
                cur[c][r] = 1'b0;
                nxt[c][r] = 1'b0;
            end
        end
        maxh = 0;
        cs   = 2'b00;
        row0 = '0;
        row1 = '0;

        for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
                cur[i+j][hgt[i+j]] = a[i] & b[j];
                hgt[i+j] = hgt[i+j] + 1;
            end
        end

        for (int s = 0; s < TILE; s++) begin
            maxh = 0;
            for (int c = 0; c < COLS; c++) begin
                if (hgt[c] > maxh) maxh = hgt[c];
            end
            if (maxh > 2) begin
                for (int c = 0; c < COLS; c++) begin
                    nh[c] = 0;
                    for (int r = 0; r < TILE; r++) nxt[c][r] = 1'b0;
                end
                for (int c = 0; c < COLS; c++) begin
                    for (int r = 0; r < TILE; r += 3) begin
                        if (r + 2 < hgt[c]) begin
                            cs = fa(cur[c][r], cur[c][r+1], cur[c][r+2]);
                            nxt[c][nh[c]] = cs[0];
                            nh[c] = nh[c] + 1;
                            if (c + 1 < COLS) begin
                                nxt[c+1][nh[c+1]] = cs[1];
                                nh[c+1] = nh[c+1] + 1;
                            end
                        end else if (r + 1 < hgt[c]) begin
                            cs = ha(cur[c][r], cur[c][r+1]);
                            nxt[c][nh[c]] = cs[0];
                            nh[c] = nh[c] + 1;
                            if (c + 1 < COLS) begin
                                nxt[c+1][nh[c+1]] = cs[1];
                                nh[c+1] = nh[c+1] + 1;
                            end
                        end else if (r < hgt[c]) begin
                            nxt[c][nh[c]] = cur[c][r];
                            nh[c] = nh[c] + 1;
                        end
                    end
                end
                for (int c = 0; c < COLS; c++) begin
                    hgt[c] = nh[c];
                    for (int r = 0; r < TILE; r++) cur[c][r] = nxt[c][r];
                end
            end
        end

        for (int c = 0; c < COLS; c++) begin
            row0[c] = cur[c][0];
            row1[c] = cur[c][1];
        end
        p = row0 + row1;
    end

endmodule

// File: rtl/tile_seq_mult.sv
// Time-multiplexed unsigned multiplier: one TILE x TILE partial product per cycle, shifted and
// accumulated, with optional skipping of low-significance tiles. Valid/ready on both sides.
module tile_seq_mult
    import mult_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int TILE     = 8,
    parameter int APPROX_W = $clog2(2 * WIDTH / TILE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [APPROX_W-1:0]  approx_lvl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int NK     = WIDTH / TILE;
    localparam int NCNT_W = $clog2(NK * NK);
    localparam int HALF   = NCNT_W / 2;
    localparam int NACC_W = 2 * WIDTH;
    localparam int LAST   = NK * NK - 1;

    state_t              state;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [APPROX_W-1:0] lvl_reg;
    logic [NACC_W-1:0]   acc;
    logic [NACC_W-1:0]   acc_next;
    logic [NACC_W-1:0]   pp_shifted;
    logic [NCNT_W-1:0]   cnt;
    logic [HALF-1:0]     ti;
    logic [HALF-1:0]     tj;
    logic [TILE-1:0]     a_tile;
    logic [TILE-1:0]     b_tile;
    logic [2*TILE-1:0]   pp;
    logic                keep;

    // Upper counter half walks the A tiles, lower half the B tiles.
    assign ti     = cnt[NCNT_W-1:HALF];
    assign tj     = cnt[HALF-1:0];
    assign a_tile = TILE'(a_reg >> tile_shift(int'(ti), 0, TILE));
    assign b_tile = TILE'(b_reg >> tile_shift(0, int'(tj), TILE));

    tile_mul_wallace #(
        .TILE (TILE)
    ) u_tile (
        .a (a_tile),
        .b (b_tile),
        .p (pp)
    );

    // Skipped tiles still spend their cycle so latency stays data-independent.
    assign keep       = (int'(ti) + int'(tj)) >= int'(lvl_reg);
    assign pp_shifted = keep ? (NACC_W'(pp) << tile_shift(int'(ti), int'(tj), TILE)) : '0;
    assign acc_next   = acc + pp_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_p     <= '0;
            acc       <= '0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            lvl_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        lvl_reg  <= approx_lvl;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == NCNT_W'(LAST)) begin
                        out_p     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_seq_mult.sv
// Self-checking bench for tile_seq_mult (16x16, 8x8 tiles): vector table, corner sequences,
// and a random run with output stalls, all checked through an expected-result queue.
module tb_tile_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  approx_lvl;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;
    logic        busy;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  lvl;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] expQ [$];
    int          tests = 0;
    int          fails = 0;
    int          inCount = 0;
    int          outCount = 0;
    int          readyMode = 1;

    tile_seq_mult #(
        .WIDTH    (16),
        .TILE     (8),
        .APPROX_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .approx_lvl (approx_lvl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Consumer side: 0 = stall, 1 = always ready, otherwise random stalls.
    always @(posedge clk) begin
        #2;
        case (readyMode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard pop on every output handoff.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            outCount++;
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", out_p);
            end else begin
                checkOutput($sformatf("result_%0d", outCount), out_p, expQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [1:0] lvl,
                                 input logic [31:0] exp, input bit push);
        bit accepted;
        accepted   = 1'b0;
        in_a       = a;
        in_b       = b;
        approx_lvl = lvl;
        in_valid   = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        end else if (push) begin
            expQ.push_back(exp);
            inCount++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runTimed(input vec_t v);
        int lat;
        lat = 0;
        applyStimulus(v.a, v.b, v.lvl, v.exp, 1'b1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        checkOutput({v.name, "_latency"}, 32'(lat), 32'd4);
        @(posedge clk);
        #1;
        checkOutput({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({v.name, "_held_p"}, out_p, v.exp);
    endtask

    initial begin
        bit          seen;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 2'd0, 32'hFFFE0001, "exact_max"};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 2'd1, 32'hFFFD0200, "approx1"};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 2'd3, 32'h00000000, "approx3_all_skipped"};
        vecs[3] = '{16'h0000, 16'hFFFF, 2'd0, 32'h00000000, "zero_a"};
        vecs[4] = '{16'h0100, 16'h0100, 2'd0, 32'h00010000, "cross_tile"};
        vecs[5] = '{16'hFFFF, 16'hFF00, 2'd2, 32'hFE010000, "approx2_high_only"};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        approx_lvl = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_out_p", out_p, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) runTimed(vecs[k]);

        // Backpressure: result must hold while the consumer stalls, and new requests are ignored.
        readyMode = 0;
        applyStimulus(16'h1234, 16'h5678, 2'd0, 32'h06260060, 1'b1);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("bp_out_valid", 32'(seen), 32'd1);
        for (int k = 0; k < 3; k++) begin
            in_a     = 16'hAAAA;
            in_b     = 16'h5555;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold_p_%0d", k), out_p, 32'h06260060);
            checkOutput($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        readyMode = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp_after_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_after_out_valid", 32'(out_valid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("bp_ignored_no_output", 32'(out_valid), 32'd0);

        // Reset in the middle of an operation discards it entirely.
        applyStimulus(16'hFFFF, 16'hFFFF, 2'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        runTimed('{16'd3, 16'd5, 2'd0, 32'd15, "after_abort"});

        readyMode = 2;
        for (int n = 0; n < 2000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus(ra, rb, 2'd0, {16'h0, ra} * {16'h0, rb}, 1'b1);
        end

        readyMode = 1;
        for (int n = 0; n < 200; n++) begin
            if (expQ.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("transfer_count", 32'(outCount), 32'(inCount));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
